// File: rtl/conv2d_engine.sv
// 3x3 convolution engine: walks output windows row-major, fetches nine pixels per
// window from an external synchronous-read image memory and writes one result each.
module conv2d_engine #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int STRIDE = 1,
    localparam int OW    = (IMG_W - 3) / STRIDE + 1,
    localparam int OH    = (IMG_H - 3) / STRIDE + 1,
    localparam int AW    = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
    localparam int OAW   = (OW * OH > 1) ? $clog2(OW * OH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic                     k_we,
    input  logic [3:0]               k_addr,
    input  logic signed [DATA_W-1:0] k_wdata,
    output logic                     img_rd_en,
    output logic [AW-1:0]            img_rd_addr,
    input  logic signed [DATA_W-1:0] img_rd_data,
    output logic                     out_we,
    output logic [OAW-1:0]           out_addr,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = (OH > 1) ? $clog2(OH) : 1;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FIN} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [3:0]                tap;
    logic [3:0]                mac_tap;
    logic                      mac_valid;
    logic [RW-1:0]             orow;
    logic [CW-1:0]             ocol;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  kernel [9];
    logic                      relu_q;
    logic [1:0]                kr;
    logic [1:0]                kc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic                      last_col;
    logic                      last_row;

    always_comb begin
        kr = 2'd0;
        kc = 2'd0;
        case (tap)
            4'd0: begin kr = 2'd0; kc = 2'd0; end
            4'd1: begin kr = 2'd0; kc = 2'd1; end
            4'd2: begin kr = 2'd0; kc = 2'd2; end
            4'd3: begin kr = 2'd1; kc = 2'd0; end
            4'd4: begin kr = 2'd1; kc = 2'd1; end
            4'd5: begin kr = 2'd1; kc = 2'd2; end
            4'd6: begin kr = 2'd2; kc = 2'd0; end
            4'd7: begin kr = 2'd2; kc = 2'd1; end
            4'd8: begin kr = 2'd2; kc = 2'd2; end
            default: begin kr = 2'd0; kc = 2'd0; end
        endcase
    end

    // Pixel data lags the read by one cycle, so the MAC uses the tap registered with it.
    assign prod     = (2*DATA_W)'(img_rd_data) * (2*DATA_W)'(kernel[mac_tap]);
    assign prod_ext = ACC_W'(prod);
    assign last_col = (ocol == CW'(OW - 1));
    assign last_row = (orow == RW'(OH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        img_rd_en   = 1'b0;
        img_rd_addr = '0;
        out_we      = 1'b0;
        out_addr    = '0;
        out_data    = '0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH;
            end
            FETCH: begin
                img_rd_en   = 1'b1;
                img_rd_addr = AW'((32'(orow) * STRIDE + 32'(kr)) * IMG_W
                                  + 32'(ocol) * STRIDE + 32'(kc));
                if (tap == 4'd8) next_state = DRAIN;
            end
            DRAIN: begin
                next_state = WRITE;
            end
            WRITE: begin
                out_we     = 1'b1;
                out_addr   = OAW'(32'(orow) * OW + 32'(ocol));
                out_data   = (relu_q && acc[ACC_W-1]) ? '0 : acc;
                next_state = (last_row && last_col) ? FIN : FETCH;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap       <= '0;
            mac_tap   <= '0;
            mac_valid <= 1'b0;
            orow      <= '0;
            ocol      <= '0;
            acc       <= '0;
            relu_q    <= 1'b0;
            for (int i = 0; i < 9; i++) kernel[i] <= '0;
        end else begin
            mac_valid <= (state == FETCH);
            mac_tap   <= tap;
            // Tap 0 loads rather than accumulates, so windows need no clear cycle.
            if (mac_valid) acc <= (mac_tap == 4'd0) ? prod_ext : acc + prod_ext;
            case (state)
                IDLE: begin
                    if (k_we && k_addr <= 4'd8) kernel[k_addr] <= k_wdata;
                    if (start) begin
                        relu_q <= relu_en;
                        orow   <= '0;
                        ocol   <= '0;
                        tap    <= '0;
                        acc    <= '0;
                    end
                end
                FETCH: begin
                    tap <= (tap == 4'd8) ? 4'd0 : tap + 4'd1;
                end
                WRITE: begin
                    if (last_col) begin
                        ocol <= '0;
                        orow <= last_row ? '0 : orow + RW'(1);
                    end else begin
                        ocol <= ocol + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_engine.sv
// Bench for conv2d_engine: a stride-1 and a stride-2 instance share one image memory
// and are checked against a loop-based convolution model.
module tb_conv2d_engine;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_a = 1'b0;
    logic               start_b = 1'b0;
    logic               k_we_a = 1'b0;
    logic               k_we_b = 1'b0;
    logic               relu_en = 1'b0;
    logic [3:0]         k_addr = 4'd0;
    logic signed [15:0] k_wdata = 16'sd0;

    logic               rd_en_a, rd_en_b;
    logic [5:0]         rd_addr_a, rd_addr_b;
    logic signed [15:0] rd_data_a = 16'sd0;
    logic signed [15:0] rd_data_b = 16'sd0;
    logic               we_a, we_b;
    logic [5:0]         oaddr_a;
    logic [3:0]         oaddr_b;
    logic signed [39:0] odata_a, odata_b;
    logic               busy_a, busy_b, done_a, done_b;

    conv2d_engine #(.IMG_W(8), .IMG_H(8), .DATA_W(16), .ACC_W(40), .STRIDE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .relu_en(relu_en),
        .k_we(k_we_a), .k_addr(k_addr), .k_wdata(k_wdata),
        .img_rd_en(rd_en_a), .img_rd_addr(rd_addr_a), .img_rd_data(rd_data_a),
        .out_we(we_a), .out_addr(oaddr_a), .out_data(odata_a),
        .busy(busy_a), .done(done_a)
    );

    conv2d_engine #(.IMG_W(8), .IMG_H(8), .DATA_W(16), .ACC_W(40), .STRIDE(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .relu_en(relu_en),
        .k_we(k_we_b), .k_addr(k_addr), .k_wdata(k_wdata),
        .img_rd_en(rd_en_b), .img_rd_addr(rd_addr_b), .img_rd_data(rd_data_b),
        .out_we(we_b), .out_addr(oaddr_b), .out_data(odata_b),
        .busy(busy_b), .done(done_b)
    );

    logic signed [15:0] img [64];
    longint             kern_m [2][9];
    longint             kset [9];
    bit                 cur_relu [2];
    int                 checks = 0;
    int                 errors = 0;
    int                 edge_cnt = 0;
    int                 start_edge [2];
    int                 wr_base [2];
    int                 done_base [2];
    int                 n_wr [2];
    int                 n_done [2];
    int                 first_we [2];
    int                 done_cyc [2];
    int                 overlap = 0;
    int                 wr_addr [2][1024];
    longint             wr_data [2][1024];

    always #5 clk = ~clk;

    // Synchronous-read image memory: data valid the cycle after the request.
    always @(posedge clk) begin
        edge_cnt  <= edge_cnt + 1;
        rd_data_a <= img[rd_addr_a];
        rd_data_b <= img[rd_addr_b];
    end

    always @(negedge clk) begin
        if (rd_en_a && we_a) overlap++;
        if (rd_en_b && we_b) overlap++;
        if (we_a) begin
            if (n_wr[0] == wr_base[0]) first_we[0] = edge_cnt - start_edge[0] + 1;
            if (n_wr[0] < 1024) begin
                wr_addr[0][n_wr[0]] = int'(oaddr_a);
                wr_data[0][n_wr[0]] = longint'(odata_a);
            end
            n_wr[0]++;
        end
        if (we_b) begin
            if (n_wr[1] == wr_base[1]) first_we[1] = edge_cnt - start_edge[1] + 1;
            if (n_wr[1] < 1024) begin
                wr_addr[1][n_wr[1]] = int'(oaddr_b);
                wr_data[1][n_wr[1]] = longint'(odata_b);
            end
            n_wr[1]++;
        end
        if (done_a) begin
            n_done[0]++;
            done_cyc[0] = edge_cnt - start_edge[0] + 1;
        end
        if (done_b) begin
            n_done[1]++;
            done_cyc[1] = edge_cnt - start_edge[1] + 1;
        end
    end

    function automatic longint model(input int sel, input int r, input int c, input bit relu);
        int     s = (sel == 0) ? 1 : 2;
        longint sum = 0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                sum += longint'(img[(r * s + kr) * 8 + c * s + kc]) * kern_m[sel][kr * 3 + kc];
        if (relu && sum < 0) sum = 0;
        return sum;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_kernel(input int sel, input int tap, input longint val);
        @(negedge clk);
        k_addr  = 4'(tap);
        k_wdata = 16'(val);
        if (sel == 0) k_we_a = 1'b1; else k_we_b = 1'b1;
        @(negedge clk);
        k_we_a = 1'b0;
        k_we_b = 1'b0;
        if (tap < 9) kern_m[sel][tap] = longint'(k_wdata);
    endtask

    task automatic program_kernel(input int sel, input int ntaps);
        for (int t = 0; t < ntaps; t++) write_kernel(sel, t, kset[t]);
    endtask

    task automatic start_frame(input int sel, input bit relu, input bit with_kw);
        @(negedge clk);
        relu_en         = relu;
        cur_relu[sel]   = relu;
        start_edge[sel] = edge_cnt + 1;
        wr_base[sel]    = n_wr[sel];
        done_base[sel]  = n_done[sel];
        if (with_kw) begin
            k_addr  = 4'd8;
            k_wdata = 16'(kset[8]);
            if (sel == 0) k_we_a = 1'b1; else k_we_b = 1'b1;
        end
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        k_we_a  = 1'b0;
        k_we_b  = 1'b0;
        if (with_kw) kern_m[sel][8] = longint'(k_wdata);
        check("busy after start", (sel == 0) ? busy_a : busy_b, 1);
    endtask

    // Optionally disturbs the frame: extra start, weight write and relu flip while busy.
    task automatic wait_done(input int sel, input bit disturb);
        int i = 0;
        while (n_done[sel] == done_base[sel] && i < 2000) begin
            i++;
            if (disturb && i == 4) begin
                relu_en = ~relu_en;
                k_addr  = 4'd0;
                k_wdata = 16'sd7777;
                if (sel == 0) begin start_a = 1'b1; k_we_a = 1'b1; end
                else          begin start_b = 1'b1; k_we_b = 1'b1; end
            end
            if (disturb && i == 5) begin
                start_a = 1'b0; start_b = 1'b0; k_we_a = 1'b0; k_we_b = 1'b0;
            end
            @(negedge clk);
        end
        start_a = 1'b0; start_b = 1'b0; k_we_a = 1'b0; k_we_b = 1'b0;
        check("frame completes within budget", i < 2000, 1);
        repeat (3) @(negedge clk);
        check("busy low after done", (sel == 0) ? busy_a : busy_b, 0);
    endtask

    task automatic check_frame(input int sel, input string name);
        int ow = (sel == 0) ? 6 : 3;
        int n  = ow * ow;
        int b  = wr_base[sel];
        check({name, " write count"}, n_wr[sel] - b, n);
        check({name, " done pulses"}, n_done[sel] - done_base[sel], 1);
        check({name, " done cycle"}, done_cyc[sel], n * 11 + 1);
        check({name, " first write cycle"}, first_we[sel], 11);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s out_addr[%0d]", name, i), wr_addr[sel][b + i], i);
            check($sformatf("%s out_data[%0d]", name, i), wr_data[sel][b + i],
                  model(sel, i / ow, i % ow, cur_relu[sel]));
        end
    endtask

    task automatic set_edge_kernel(input longint sgn);
        kset[0] = -sgn; kset[1] = -sgn; kset[2] = -sgn;
        kset[3] = 0;    kset[4] = 0;    kset[5] = 0;
        kset[6] = sgn;  kset[7] = sgn;  kset[8] = sgn;
    endtask

    initial begin
        for (int a = 0; a < 64; a++) img[a] = 16'(a);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset img_rd_en", rd_en_a, 0);
        check("reset img_rd_addr", rd_addr_a, 0);
        check("reset out_we", we_a, 0);
        check("reset out_addr", oaddr_a, 0);
        check("reset out_data", odata_a, 0);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] step: gradient kernel, stride 1");
        for (int t = 9; t < 16; t++) write_kernel(0, t, 5);
        set_edge_kernel(1);
        program_kernel(0, 9);
        start_frame(0, 1'b0, 1'b0);
        wait_done(0, 1'b0);
        check_frame(0, "grad");
        check("grad first result", wr_data[0][wr_base[0]], 48);
        check("grad last result", wr_data[0][wr_base[0] + 35], 48);

        $display("[TB] step: negated kernel with busy disturbance, relu off then on");
        set_edge_kernel(-1);
        program_kernel(0, 9);
        start_frame(0, 1'b0, 1'b0);
        wait_done(0, 1'b1);
        check_frame(0, "neg");
        check("neg result", wr_data[0][wr_base[0] + 7], -48);
        start_frame(0, 1'b1, 1'b0);
        wait_done(0, 1'b0);
        check_frame(0, "neg relu");
        check("neg relu result", wr_data[0][wr_base[0] + 20], 0);

        $display("[TB] step: start and weight write while busy");
        set_edge_kernel(1);
        program_kernel(0, 9);
        start_frame(0, 1'b0, 1'b0);
        wait_done(0, 1'b1);
        check_frame(0, "busy ignore");
        check("busy ignore result", wr_data[0][wr_base[0] + 13], 48);

        $display("[TB] step: reset during third window");
        start_frame(0, 1'b0, 1'b0);
        repeat (24) @(negedge clk);
        check("abort point is a fetch", rd_en_a, 1);
        rst = 1'b1;
        #1;
        check("abort img_rd_en", rd_en_a, 0);
        check("abort img_rd_addr", rd_addr_a, 0);
        check("abort out_we", we_a, 0);
        check("abort out_addr", oaddr_a, 0);
        check("abort out_data", odata_a, 0);
        check("abort busy", busy_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) for (int t = 0; t < 9; t++) kern_m[s][t] = 0;
        repeat (60) @(negedge clk);
        check("abort write count", n_wr[0] - wr_base[0], 2);
        check("abort last address", wr_addr[0][wr_base[0] + 1], 1);
        check("abort no done", n_done[0] - done_base[0], 0);

        $display("[TB] step: kernels cleared by reset");
        start_frame(1, 1'b0, 1'b0);
        wait_done(1, 1'b0);
        check_frame(1, "zero kernel");

        $display("[TB] step: restart with tap 8 written alongside start");
        set_edge_kernel(1);
        program_kernel(0, 8);
        start_frame(0, 1'b0, 1'b1);
        wait_done(0, 1'b0);
        check_frame(0, "restart");
        check("restart result", wr_data[0][wr_base[0] + 35], 48);

        $display("[TB] step: stride 2 centre tap");
        for (int t = 0; t < 9; t++) kset[t] = (t == 4) ? 1 : 0;
        program_kernel(1, 9);
        start_frame(1, 1'b0, 1'b0);
        wait_done(1, 1'b0);
        check_frame(1, "stride2");
        check("stride2 out[0]", wr_data[1][wr_base[1]], 9);
        check("stride2 out[8]", wr_data[1][wr_base[1] + 8], 45);

        $display("[TB] step: most negative pixels and weights");
        for (int a = 0; a < 64; a++) img[a] = -16'sd32768;
        for (int t = 0; t < 9; t++) kset[t] = -32768;
        program_kernel(0, 9);
        start_frame(0, 1'b0, 1'b0);
        wait_done(0, 1'b0);
        check_frame(0, "extreme");
        check("extreme result", wr_data[0][wr_base[0]], 64'sd9663676416);

        $display("[TB] step: random frames");
        for (int f = 0; f < 4; f++) begin
            int sel = f % 2;
            for (int a = 0; a < 64; a++) img[a] = 16'($urandom);
            for (int t = 0; t < 9; t++) kset[t] = longint'($signed(16'($urandom)));
            program_kernel(sel, 9);
            start_frame(sel, 1'($urandom_range(0, 1)), 1'b0);
            wait_done(sel, 1'b0);
            check_frame(sel, $sformatf("random%0d", f));
        end

        check("read and write never overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_engine.md
CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 SHALL have parameter IMG_W, default 8: input image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 8: input image height in pixels (>=3).
REQ-003 SHALL have parameter DATA_W, default 16: signed pixel and weight width.
REQ-004 SHALL have parameter ACC_W, default 40: signed accumulator and output width; the value SHALL be at least 2*DATA_W+4.
REQ-005 SHALL have parameter STRIDE, default 1: window step, 1 or 2; OW=(IMG_W-3)/STRIDE+1 and OH=(IMG_H-3)/STRIDE+1.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 start  in  1  one-cycle request to begin a frame.
REQ-009 relu_en  in  1  clamp negative results to 0 when 1.
REQ-010 k_we  in  1  kernel weight write strobe.
REQ-011 k_addr  in  4  tap index 0..8, where tap = kr*3+kc.
REQ-012 k_wdata  in  DATA_W  signed weight.
REQ-013 img_rd_en  out  1  pixel read request.
REQ-014 img_rd_addr  out  clog2(IMG_W*IMG_H)  pixel address, row-major.
REQ-015 img_rd_data  in  DATA_W  signed pixel, valid exactly one cycle after img_rd_en.
REQ-016 out_we  out  1  result write strobe.
REQ-017 out_addr  out  clog2(OW*OH)  result address, orow*OW+ocol.
REQ-018 out_data  out  ACC_W  signed result.
REQ-019 busy  out  1  high from start acceptance until done.
REQ-020 done  out  1  one-cycle pulse at frame completion.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, DRAIN, WRITE and FIN.
REQ-022 IDLE: start=1 SHALL latch relu_en, clear orow/ocol/tap/acc, set busy, and go to FETCH.
REQ-023 FETCH: each cycle for tap 0..8 SHALL assert img_rd_en with img_rd_addr=(orow*STRIDE+kr)*IMG_W+ocol*STRIDE+kc; after tap 8 go to DRAIN.
REQ-024 The block SHALL do acc += img_rd_data*kernel[tap-1] in the cycle after each read (FETCH taps 1..8 and DRAIN); the product SHALL be a full-width signed product, sign-extended to ACC_W, with no saturation.
REQ-025 Tap 0 of each window SHALL load acc with its product instead of adding it, so no separate clear cycle is needed.
REQ-026 WRITE SHALL assert out_we for one cycle with out_addr=orow*OW+ocol and out_data=(relu latched && acc<0) ? 0 : acc.
REQ-027 After WRITE, the block SHALL advance ocol; on ocol=OW-1 it SHALL wrap ocol to 0 and advance orow; if orow=OH-1 and ocol=OW-1 it SHALL go to FIN, otherwise to FETCH.
REQ-028 Per-window latency SHALL be 11 cycles (9 FETCH, 1 DRAIN, 1 WRITE); the first out_we SHALL occur in the 11th cycle after start is accepted.
REQ-029 FIN SHALL pulse done for one cycle, clear busy, and return to IDLE; total frame time SHALL be OW*OH*11+1 cycles.
REQ-030 The kernel SHALL be 9 DATA_W registers written when k_we=1, only in IDLE; writes with k_addr>8 or while busy SHALL be ignored.
REQ-031 start while busy SHALL be ignored; start and k_we in the same IDLE cycle SHALL perform both, with the new weight used in the frame.
REQ-032 img_rd_en and out_we SHALL never be asserted in the same cycle; both SHALL be low outside FETCH and WRITE respectively.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE and img_rd_en=0, out_we=0, busy=0, done=0, img_rd_addr=0, out_addr=0, out_data=0, acc=0, and all kernel weights to 0.
REQ-034 Reset mid-frame SHALL abort the frame with no further out_we or done; a new start after release SHALL run a full frame.

Verification
REQ-035 8x8, STRIDE=1, pixel[a]=a, kernel rows {-1,-1,-1},{0,0,0},{1,1,1}, relu_en=0 -> 36 writes, every out_data=48, addresses 0..35 in order, done at cycle 397.
REQ-036 Same image, negated kernel: relu_en=0 -> every result -48; relu_en=1 -> every result 0.
REQ-037 8x8, STRIDE=2, only kernel tap 4=1 -> 9 writes; out[r*3+c]=pixel[(2r+1)*8+2c+1], e.g. out[0]=9, out[8]=45.
REQ-038 start pulsed at cycle 5 of a frame, and k_we while busy -> no restart, kernel unchanged, results identical to REQ-035.
REQ-039 rst asserted during the 3rd window's FETCH -> outputs cleared at once, no write to address 2 or later, no done; a restart after reprogramming the kernel gives the REQ-035 results.
REQ-040 Pixels -32768 with all weights -32768 (DATA_W=16) -> out_data=9*2^30=9663676416 with no overflow.
